// File: rtl/seq_multiplier_pkg.sv
// Shared arithmetic package for the sequential multiplier.
// Contents:
//   state_t / ST_*        FSM state type and encodings (IDLE/BUSY/DONE)
//   SUPPORTED_WIDTHS      operand widths the multiplier can be built with
//   width_supported()     elaboration-time check against that list
package seq_multiplier_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_BUSY = 2'b01;
  localparam state_t ST_DONE = 2'b10;

  localparam int NUM_WIDTHS = 5;
  // Entry 0 is the narrowest width.
  localparam logic [NUM_WIDTHS-1:0][7:0] SUPPORTED_WIDTHS =
    {8'd64, 8'd32, 8'd16, 8'd8, 8'd4};

  function automatic bit width_supported(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_WIDTHS; i++) begin
      if (w == 32'(SUPPORTED_WIDTHS[i])) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/seq_multiplier_adder.sv
// Carry-lookahead adder (parallel-prefix carry network).
// Ports:
//   a, b  [WIDTH-1:0]  addends
//   cin                carry in
//   sum   [WIDTH-1:0]  a + b + cin (low WIDTH bits)
//   cout               carry out
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  always_comb begin
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] gn;
    logic [WIDTH-1:0] pn;
    logic [WIDTH:0]   c;
    int               d;

    p  = a ^ b;
    gg = a & b;
    pp = p;
    // Each level doubles the span of the group generate/propagate terms,
    // so after LEVELS steps bit i summarises bits [i:0].
    for (int l = 0; l < LEVELS; l++) begin
      d  = 1 << l;
      gn = gg;
      pn = pp;
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= d) begin
          gn[i] = gg[i] | (pp[i] & gg[i-d]);
          pn[i] = pp[i] & pp[i-d];
        end
      end
      gg = gn;
      pp = pn;
    end

    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = gg[i] | (pp[i] & cin);
    end

    sum  = p ^ c[WIDTH-1:0];
    cout = c[WIDTH];
  end

endmodule

// File: rtl/seq_multiplier.sv
// Fixed-latency shift-and-add unsigned multiplier.
// One operand pair is accepted in IDLE; WIDTH BUSY iterations follow; the
// product is then held in DONE until the consumer takes it.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Producers hold valid and data until that edge; ready may depend on
// state only, never on the partner's valid.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake (in_ready only in IDLE)
//   in1, in2              unsigned multiplicand / multiplier
//   out_valid/out_ready   product handshake (out_valid only in DONE)
//   out                   2*WIDTH product register
//   busy                  high while iterating
//   dbg_state             current FSM state for checkers
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  if (!width_supported(WIDTH)) begin : g_bad_width
    $error("seq_multiplier: unsupported WIDTH %0d", WIDTH);
  end

  // One extra bit so the count can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t               state;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mcand;
  logic [CW-1:0]        cnt;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     psum;
  logic                 pcarry;

  assign addend = prod[0] ? mcand : '0;

  adder #(.WIDTH(WIDTH)) u_adder (
    .a    (prod[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (psum),
    .cout (pcarry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      prod  <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand <= in1;
            prod  <= {{WIDTH{1'b0}}, in2};
            cnt   <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Carry out of the partial sum becomes the new top bit as the
          // register shifts right by one.
          prod <= {pcarry, psum, prod[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_ITER) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_BUSY);
  assign out_valid = (state == ST_DONE);
  assign out       = prod;
  assign dbg_state = state;

endmodule
